// File: rtl/interrupt_sequencer.sv
// 8259-style interrupt control core: IRR/ISR tracking, priority resolution and INT/INTA handshake.
// Define ROTATE_PRIORITY_EN to add the rotating lowest-priority register and the rotate OCW2 commands.
module interrupt_sequencer #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] IR,
  input  logic [NUM_IR-1:0] IMR,
  input  logic              LTIM,
  input  logic              EOI_mode,
  input  logic [4:0]        VEC_ADD,
  input  logic [2:0]        EOI_command,
  input  logic [2:0]        int_level,
  input  logic              ocw2_wr,
  input  logic              read_mode,
  input  logic              INTA,
  output logic              INT,
  output logic              int_flag,
  output logic [7:0]        vector_out,
  output logic [NUM_IR-1:0] status_out,
  output logic [NUM_IR-1:0] ISR,
  output logic [NUM_IR-1:0] IRR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK1 = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NUM_IR-1:0] r_irr;
  logic [NUM_IR-1:0] r_isr;
  logic [NUM_IR-1:0] r_ir_prev;
  logic              r_inta_prev;
  logic              r_int;
  logic              r_int_flag;
  logic [7:0]        r_vector;
  logic [2:0]        r_level;
  logic              r_spurious;

  logic              w_inta_fall;
  logic              w_inta_rise;
  logic [2:0]        w_base;
  logic [NUM_IR-1:0] w_pend;
  logic [3:0]        w_pend_ff;
  logic [3:0]        w_isr_ff;
  logic              w_req;
  logic [2:0]        w_winner;
  logic [2:0]        w_isr_top;
  logic              w_ack;
  logic [2:0]        w_ack_level;
  logic              w_ack_spur;
  logic              w_vec_load;
  logic              w_done;
  logic              w_eoi_ns;
  logic              w_eoi_sp;
  logic [NUM_IR-1:0] w_ack_set;
  logic [NUM_IR-1:0] w_eoi_clr;
  logic [NUM_IR-1:0] w_aeoi_clr;
  logic [NUM_IR-1:0] w_irr_next;

  // Rotate so that the highest-priority line lands at bit 0.
  function automatic logic [NUM_IR-1:0] rot_down(input logic [NUM_IR-1:0] v, input logic [2:0] sh);
    logic [2*NUM_IR-1:0] w;
    w = {v, v} >> sh;
    return w[NUM_IR-1:0];
  endfunction

  // {found, index of lowest set bit}
  function automatic logic [3:0] find_first(input logic [NUM_IR-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [NUM_IR-1:0] onehot(input logic [2:0] lvl);
    return NUM_IR'(1) << lvl;
  endfunction

`ifdef ROTATE_PRIORITY_EN
  logic [2:0] r_lp;
  logic       r_rot_aeoi;
  assign w_base = r_lp + 3'd1;
`else
  assign w_base = 3'd0;
`endif

  assign w_inta_fall = !INTA && r_inta_prev;
  assign w_inta_rise = INTA && !r_inta_prev;

  assign w_pend    = r_irr & ~IMR;
  assign w_pend_ff = find_first(rot_down(w_pend, w_base));
  assign w_isr_ff  = find_first(rot_down(r_isr, w_base));
  // Ranks are compared in the rotated domain, so nesting follows the current priority order.
  assign w_req     = w_pend_ff[3] && (!w_isr_ff[3] || (w_pend_ff[2:0] < w_isr_ff[2:0]));
  assign w_winner  = w_pend_ff[2:0] + w_base;
  assign w_isr_top = w_isr_ff[2:0] + w_base;

  always_comb begin
    w_next      = r_state;
    w_ack       = 1'b0;
    w_ack_level = r_level;
    w_ack_spur  = r_spurious;
    w_vec_load  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = S_PEND;
        end else if (w_inta_fall) begin
          w_next      = S_ACK1;
          w_ack       = 1'b1;
          w_ack_level = 3'd7;
          w_ack_spur  = 1'b1;
        end
      end
      S_PEND: begin
        if (w_inta_fall) begin
          w_next      = S_ACK1;
          w_ack       = 1'b1;
          w_ack_level = w_req ? w_winner : 3'd7;
          w_ack_spur  = !w_req;
        end else if (!w_req) begin
          w_next = S_IDLE;
        end
      end
      S_ACK1: begin
        if (w_inta_fall) begin
          w_next     = S_ACK2;
          w_vec_load = 1'b1;
        end
      end
      S_ACK2: begin
        if (w_inta_rise) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_eoi_ns = ocw2_wr && ((EOI_command == 3'b001) || (EOI_command == 3'b101));
  assign w_eoi_sp = ocw2_wr && ((EOI_command == 3'b011) || (EOI_command == 3'b111));

  // EOI decodes against the pre-update ISR; the ACK set is OR-ed in afterwards and wins.
  assign w_ack_set  = (w_ack && !w_ack_spur) ? onehot(w_ack_level) : '0;
  assign w_eoi_clr  = ((w_eoi_ns && w_isr_ff[3]) ? onehot(w_isr_top) : '0)
                    | (w_eoi_sp ? onehot(int_level) : '0);
  assign w_aeoi_clr = (w_done && EOI_mode && !r_spurious) ? onehot(r_level) : '0;

  assign w_irr_next = LTIM ? (IR & ~w_ack_set)
                           : (IR & (r_irr | ~r_ir_prev) & ~w_ack_set);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irr       <= '0;
      r_isr       <= '0;
      r_ir_prev   <= '0;
      r_inta_prev <= 1'b1;
      r_int       <= 1'b0;
      r_int_flag  <= 1'b0;
      r_vector    <= 8'h00;
      r_level     <= 3'd0;
      r_spurious  <= 1'b0;
    end else begin
      r_irr       <= w_irr_next;
      r_isr       <= (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;
      r_ir_prev   <= IR;
      r_inta_prev <= INTA;
      r_int       <= (w_next == S_PEND);
      r_int_flag  <= (w_next == S_ACK2);
      if (w_ack) begin
        r_level    <= w_ack_level;
        r_spurious <= w_ack_spur;
      end
      if (w_vec_load) begin
        r_vector <= {VEC_ADD, r_level};
      end
    end
  end

`ifdef ROTATE_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lp       <= 3'd7;
      r_rot_aeoi <= 1'b0;
    end else begin
      if (w_done && EOI_mode && !r_spurious && r_rot_aeoi) begin
        r_lp <= r_level;
      end
      // An explicit rotate command takes precedence over an AEOI rotation in the same cycle.
      if (ocw2_wr) begin
        case (EOI_command)
          3'b101: if (w_isr_ff[3]) r_lp <= w_isr_top;
          3'b111: r_lp <= int_level;
          3'b110: r_lp <= int_level;
          3'b100: r_rot_aeoi <= 1'b1;
          3'b000: r_rot_aeoi <= 1'b0;
          default: ;
        endcase
      end
    end
  end
`endif

  assign INT        = r_int;
  assign int_flag   = r_int_flag;
  assign vector_out = r_vector;
  assign ISR        = r_isr;
  assign IRR        = r_irr;
  assign status_out = read_mode ? r_isr : r_irr;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Control core of the 8259 PIC, sitting behind the register/bus-buffer front end.
- Consumes the decoded configuration: IMR, LTIM, AEOI flag, vector base, OCW2 fields.
- Owns IRR/ISR, priority resolution and the INT/INTA handshake.
- Supplies the vector byte and drive flag used by the tri-state buffer during the second INTA.

Parameters:
- NUM_IR, 8, number of interrupt request lines. Fixed at 8; other values unsupported.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- IR  in  8  interrupt request lines; bit 0 highest fixed priority
- IMR  in  8  mask; 1 = masked
- LTIM  in  1  1 = level-triggered, 0 = edge-triggered
- EOI_mode  in  1  1 = AEOI, 0 = normal EOI
- VEC_ADD  in  5  vector base T7..T3
- EOI_command  in  3  OCW2 R/SL/EOI field
- int_level  in  3  OCW2 L2..L0
- ocw2_wr  in  1  one-cycle strobe: OCW2 written this cycle
- read_mode  in  1  0 = status_out shows IRR, 1 = ISR
- INTA  in  1  interrupt acknowledge, active-low, synchronous to clk
- INT  out  1  interrupt request to CPU
- int_flag  out  1  1 while vector is to be driven onto CPU bus
- vector_out  out  8  {VEC_ADD, level}
- status_out  out  8  IRR or ISR, per read_mode
- ISR  out  8  in-service register
- IRR  out  8  request register

Behaviour:
- Reset, and reset asserted mid-operation: IRR, ISR, vector_out = 0; INT = 0; int_flag = 0; state = IDLE; ir_prev = 0; inta_prev = 1. Reset overrides every other event in that cycle.
- IRR update, edge mode (LTIM=0):
  - IRR[i] sets on a sampled 0->1 of IR[i] (ir_prev register).
  - IRR[i] clears when IR[i] is low, or on ACK1 for the acknowledged level.
- IRR update, level mode (LTIM=1):
  - IRR[i] <= IR[i] every cycle.
  - Exception: the acknowledged bit is forced 0 in the ACK1 cycle.
- Request present (req):
  - Some i has IRR[i] & ~IMR[i].
  - Priority of i is strictly higher than the highest-priority set ISR bit. With ISR = 0, any unmasked request qualifies.
- Priority resolution is combinational; the winner is the lowest index.
- INTA falling edge (inta_fall) = INTA==0 && inta_prev==1. Rising edge likewise.
- FSM states: IDLE, PEND, ACK1, ACK2.
  - IDLE: INT=0. req -> PEND next cycle. inta_fall with no req -> ACK1 as spurious.
  - PEND: INT=1.
    - req drops -> IDLE, INT=0.
    - inta_fall -> ACK1: latch level = winner, or 7 if req has vanished (spurious). Set ISR[level] unless spurious; clear IRR[level]; INT=0.
  - ACK1: wait for the next inta_fall -> ACK2. Then vector_out = {VEC_ADD, level} and int_flag=1, both registered, valid the cycle after the fall.
  - ACK2: hold int_flag=1 until the INTA rising edge.
    - On the rising edge: int_flag=0, state -> IDLE.
    - If EOI_mode=1 and not spurious: clear ISR[level] on that same edge.
- INT is a registered output: asserted one cycle after req first seen in IDLE.
- OCW2 handling, evaluated when ocw2_wr=1:
  - 001 non-specific EOI: clear the highest-priority set ISR bit; no-op if ISR = 0.
  - 011 specific EOI: clear ISR[int_level].
  - 000/010/100/101/110/111: see Optional Feature. Without the feature, 101 behaves as 001, 111 as 011, and the others are ignored.
- Same-cycle EOI clear and ACK1 set: EOI decodes against pre-update ISR; set wins if both target the same bit.
- IMR changes act immediately on req. A masked bit already in ISR stays in ISR.
- status_out = read_mode ? ISR : IRR, combinational.

Optional Feature:
- Macro ROTATE_PRIORITY_EN.
- Defined:
  - Adds a 3-bit lowest-priority register lp, reset 7. Priority order is (lp+1) mod 8 highest, up to lp lowest; this applies to both resolution and non-specific EOI.
  - 101: non-specific EOI, then lp = cleared level.
  - 111: specific EOI, then lp = int_level.
  - 110: lp = int_level, no EOI.
  - 100: set rotate-in-AEOI; 000: clear it. When set, an AEOI clear also sets lp = level.
- Undefined: fixed priority; lp does not exist.

Test Plan:
- Edge-mode IR3 0->1, IMR=0, VEC_ADD=5'b01000:
  - INT=1 two cycles later.
  - First INTA low pulse: ISR=8'h08, IRR=0, INT=0.
  - Second INTA low: int_flag=1, vector_out=8'h43.
  - INTA rises: int_flag=0.
- IR5 and IR2 raised together: ack selects level 2, vector low bits 3'b010. After OCW2=8'h20 (001 EOI) clears ISR[2], INT reasserts for IR5.
- IR1 in service, IR4 raised: INT stays 0. IR0 raised: INT=1 (nesting); after ack ISR=8'h03.
- AEOI (EOI_mode=1), IR6: ISR[6] sets on first INTA and clears on the second INTA's rising edge; ISR=0 afterwards.
- Spurious: IR2 edge raises INT, then IR2 drops before INTA. Two INTA pulses give vector_out={VEC_ADD,3'b111}, ISR unchanged.
- Reset asserted in ACK1: next cycle all outputs 0, state IDLE. With ROTATE_PRIORITY_EN: OCW2 110 with int_level=2, then IR3 and IR7 raised -> IR3 acknowledged first.
